bounding_box_finder: RTL and testbench

Scans a fixed-size 24-bit BMP pixel array in memory and reports the smallest rectangle containing every non-background pixel. It sits upstream of the cropping stage, which consumes the four bounds. It uses the same byte-addressed, one-cycle-latency read port and the same start/done handshake as the cropping stage. The pixel array starts at address 0, with no header and no row padding.

---
 rtl/bounding_box_finder.sv | 185 ++++++++++++++++++
 tb/tb_bounding_box_finder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bounding_box_finder.sv
// Finds the smallest rectangle holding every non-background pixel of a bottom-up 24-bit BMP array.
// Latency is 6*WIDTH*HEIGHT+1 cycles from start to done; there is no backpressure, and a scan runs to completion once started.
module bounding_box_finder #(
    parameter int         WIDTH  = 100,
    parameter int         HEIGHT = 100,
    parameter logic [7:0] BG_R   = 8'hFF,
    parameter logic [7:0] BG_G   = 8'hFF,
    parameter logic [7:0] BG_B   = 8'hFF,
    parameter logic [7:0] TOL    = 8'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        done,
    output logic [31:0] readAddr,
    input  logic [15:0] readdata,
    output logic [10:0] xMin,
    output logic [10:0] xMax,
    output logic [10:0] yMin,
    output logic [10:0] yMax,
    output logic        found
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_CMP, S_FINISHED} state_t;

    localparam logic [10:0] X_LAST    = 11'(WIDTH - 1);
    localparam logic [10:0] Y_LAST    = 11'(HEIGHT - 1);
    localparam logic [31:0] ROW_TOP   = 32'(HEIGHT - 1);
    localparam logic [31:0] ROW_BYTES = 32'(WIDTH * 3);

    state_t      r_state;
    state_t      w_next_state;
    logic [10:0] r_x;
    logic [10:0] r_y;
    logic [1:0]  r_ch;
    logic        r_flag;
    logic        r_found_t;
    logic [10:0] r_xmin_t;
    logic [10:0] r_xmax_t;
    logic [10:0] r_ymin_t;
    logic [10:0] r_ymax_t;

    logic [7:0]  w_bg;
    logic [7:0]  w_byte;
    logic [7:0]  w_diff;
    logic        w_pix_fg;
    logic        w_last_ch;
    logic        w_last_px;
    logic        w_start_scan;
    logic        w_hit;
    logic [1:0]  w_k;
    logic [31:0] w_row;
    logic [31:0] w_addr;
    logic        w_nxt_found;
    logic [10:0] w_nxt_xmin;
    logic [10:0] w_nxt_xmax;
    logic [10:0] w_nxt_ymin;
    logic [10:0] w_nxt_ymax;

    // Channel index 0/1/2 walks R, G, B; in memory B sits at the lowest byte of a pixel.
    always_comb begin
        w_bg = BG_B;
        case (r_ch)
            2'd0:    w_bg = BG_R;
            2'd1:    w_bg = BG_G;
            default: w_bg = BG_B;
        endcase
    end

    assign w_byte       = readdata[7:0];
    assign w_diff       = (w_byte >= w_bg) ? (w_byte - w_bg) : (w_bg - w_byte);
    assign w_pix_fg     = r_flag | (w_diff > TOL);
    assign w_last_ch    = (r_ch == 2'd2);
    assign w_last_px    = (r_x == X_LAST) && (r_y == Y_LAST);
    assign w_start_scan = ((r_state == S_IDLE) || (r_state == S_FINISHED)) && start;
    assign w_hit        = (r_state == S_CMP) && w_last_ch && w_pix_fg;

    assign w_k      = 2'd2 - r_ch;
    assign w_row    = ROW_TOP - {21'd0, r_y};
    assign w_addr   = (w_row * ROW_BYTES) + ({21'd0, r_x} * 32'd3) + {30'd0, w_k};
    assign readAddr = ((r_state == S_READ) || (r_state == S_CMP)) ? w_addr : 32'd0;
    assign done     = (r_state == S_FINISHED);

    always_comb begin
        w_nxt_found = r_found_t;
        w_nxt_xmin  = r_xmin_t;
        w_nxt_xmax  = r_xmax_t;
        w_nxt_ymin  = r_ymin_t;
        w_nxt_ymax  = r_ymax_t;
        if (w_hit) begin
            w_nxt_found = 1'b1;
            if (!r_found_t) begin
                w_nxt_xmin = r_x;
                w_nxt_xmax = r_x;
                w_nxt_ymin = r_y;
                w_nxt_ymax = r_y;
            end else begin
                w_nxt_xmin = (r_x < r_xmin_t) ? r_x : r_xmin_t;
                w_nxt_xmax = (r_x > r_xmax_t) ? r_x : r_xmax_t;
                w_nxt_ymin = (r_y < r_ymin_t) ? r_y : r_ymin_t;
                w_nxt_ymax = (r_y > r_ymax_t) ? r_y : r_ymax_t;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:     if (start) w_next_state = S_READ;
            S_READ:     w_next_state = S_CMP;
            S_CMP:      w_next_state = (w_last_ch && w_last_px) ? S_FINISHED : S_READ;
            S_FINISHED: if (start) w_next_state = S_READ;
            default:    w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x       <= 11'd0;
            r_y       <= 11'd0;
            r_ch      <= 2'd0;
            r_flag    <= 1'b0;
            r_found_t <= 1'b0;
            r_xmin_t  <= 11'd0;
            r_xmax_t  <= 11'd0;
            r_ymin_t  <= 11'd0;
            r_ymax_t  <= 11'd0;
        end else if (w_start_scan) begin
            r_x       <= 11'd0;
            r_y       <= 11'd0;
            r_ch      <= 2'd0;
            r_flag    <= 1'b0;
            r_found_t <= 1'b0;
            r_xmin_t  <= 11'd0;
            r_xmax_t  <= 11'd0;
            r_ymin_t  <= 11'd0;
            r_ymax_t  <= 11'd0;
        end else if (r_state == S_CMP) begin
            if (!w_last_ch) begin
                r_ch   <= r_ch + 2'd1;
                r_flag <= w_pix_fg;
            end else begin
                r_ch      <= 2'd0;
                r_flag    <= 1'b0;
                r_found_t <= w_nxt_found;
                r_xmin_t  <= w_nxt_xmin;
                r_xmax_t  <= w_nxt_xmax;
                r_ymin_t  <= w_nxt_ymin;
                r_ymax_t  <= w_nxt_ymax;
                if (r_x == X_LAST) begin
                    r_x <= 11'd0;
                    r_y <= w_last_px ? 11'd0 : r_y + 11'd1;
                end else begin
                    r_x <= r_x + 11'd1;
                end
            end
        end
    end

    // Outputs publish only on entry to FINISHED so the cropper sees a stable box until the next scan ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            found <= 1'b0;
            xMin  <= 11'd0;
            xMax  <= 11'd0;
            yMin  <= 11'd0;
            yMax  <= 11'd0;
        end else if ((r_state == S_CMP) && (w_next_state == S_FINISHED)) begin
            found <= w_nxt_found;
            xMin  <= w_nxt_xmin;
            xMax  <= w_nxt_xmax;
            yMin  <= w_nxt_ymin;
            yMax  <= w_nxt_ymax;
        end
    end

endmodule

// File: tb/tb_bounding_box_finder.sv
// Bench for bounding_box_finder: two 10x10 instances (TOL 0 and TOL 2) share one image model.
module tb_bounding_box_finder;
    localparam int W = 10;
    localparam int H = 10;
    localparam int NBYTES = W * H * 3;
    localparam int SCAN_CYC = 6 * W * H + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        done0, done1, found0, found1;
    logic [31:0] addr0, addr1;
    logic [15:0] rd0 = 16'd0;
    logic [15:0] rd1 = 16'd0;
    logic [10:0] xmin0, xmax0, ymin0, ymax0, xmin1, xmax1, ymin1, ymax1;
    logic [44:0] res0, res1;

    logic [7:0] img_r[H][W];
    logic [7:0] img_g[H][W];
    logic [7:0] img_b[H][W];
    int seen_at[NBYTES];
    int scan_id = 0;
    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    bounding_box_finder #(.WIDTH(W), .HEIGHT(H), .BG_R(8'hFF), .BG_G(8'hFF), .BG_B(8'hFF), .TOL(8'd0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .done(done0), .readAddr(addr0), .readdata(rd0),
        .xMin(xmin0), .xMax(xmax0), .yMin(ymin0), .yMax(ymax0), .found(found0));

    bounding_box_finder #(.WIDTH(W), .HEIGHT(H), .BG_R(8'hFF), .BG_G(8'hFF), .BG_B(8'hFF), .TOL(8'd2)) dut_t (
        .clk(clk), .rst_n(rst_n), .start(start), .done(done1), .readAddr(addr1), .readdata(rd1),
        .xMin(xmin1), .xMax(xmax1), .yMin(ymin1), .yMax(ymax1), .found(found1));

    assign res0 = {found0, xmin0, xmax0, ymin0, ymax0};
    assign res1 = {found1, xmin1, xmax1, ymin1, ymax1};

    // Memory decodes a byte address back into (y, x, channel); top image row lives at the highest memory row.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        int row, col, y, x;
        if (a >= 32'(NBYTES)) return 8'h00;
        row = int'(a) / (W * 3);
        col = int'(a) % (W * 3);
        y = H - 1 - row;
        x = col / 3;
        case (col % 3)
            2:       return img_r[y][x];
            1:       return img_g[y][x];
            default: return img_b[y][x];
        endcase
    endfunction

    always @(posedge clk) begin
        rd0 <= {8'($urandom), mem_byte(addr0)};
        rd1 <= {8'($urandom), mem_byte(addr1)};
        if (addr0 < 32'(NBYTES)) seen_at[addr0] <= scan_id;
    end

    function automatic int absdiff(input logic [7:0] v);
        int d;
        d = int'(v) - 255;
        return (d < 0) ? -d : d;
    endfunction

    function automatic logic [44:0] ref_box(input int tol);
        logic f;
        int x0, x1, y0, y1;
        f = 1'b0; x0 = 0; x1 = 0; y0 = 0; y1 = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (absdiff(img_r[y][x]) > tol || absdiff(img_g[y][x]) > tol || absdiff(img_b[y][x]) > tol) begin
                    if (!f) begin
                        f = 1'b1; x0 = x; x1 = x; y0 = y; y1 = y;
                    end else begin
                        if (x < x0) x0 = x;
                        if (x > x1) x1 = x;
                        if (y < y0) y0 = y;
                        if (y > y1) y1 = y;
                    end
                end
            end
        end
        return {f, 11'(x0), 11'(x1), 11'(y0), 11'(y1)};
    endfunction

    function automatic logic [44:0] box(input logic f, input int a, input int b, input int c, input int d);
        return {f, 11'(a), 11'(b), 11'(c), 11'(d)};
    endfunction

    task automatic fill_bg();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                img_r[y][x] = 8'hFF; img_g[y][x] = 8'hFF; img_b[y][x] = 8'hFF;
            end
    endtask

    task automatic run_scan(output int cyc);
        int n;
        scan_id++;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (!done0 && n < 4000) begin
            @(posedge clk); #1;
            n++;
        end
        cyc = n + 1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({done0, res0, done1, res1} !== 92'd0) $display("FAIL reset_outputs: got %h want 0", {done0, res0, done1, res1});
        else n_pass++;
        n_checks++;
        if (addr0 !== 32'd0) $display("FAIL reset_addr: got %0d want 0", addr0);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_all_bg();
        int cyc;
        fill_bg();
        run_scan(cyc);
        n_checks++;
        if (cyc !== SCAN_CYC) $display("FAIL allbg_latency: got %0d want %0d", cyc, SCAN_CYC);
        else n_pass++;
        n_checks++;
        if (res0 !== 45'd0) $display("FAIL allbg_box: got %h want 0", res0);
        else n_pass++;
        n_checks++;
        if (res1 !== 45'd0 || done1 !== 1'b1) $display("FAIL allbg_box_tol: got %h done %b want 0 done 1", res1, done1);
        else n_pass++;
        repeat (10) @(negedge clk);
        n_checks++;
        if (done0 !== 1'b1 || res0 !== 45'd0) $display("FAIL allbg_hold: got done %b box %h want done 1 box 0", done0, res0);
        else n_pass++;
    endtask

    task automatic test_single();
        int cyc;
        fill_bg();
        img_r[7][3] = 8'hFE;
        run_scan(cyc);
        n_checks++;
        if (cyc !== SCAN_CYC) $display("FAIL single_latency: got %0d want %0d", cyc, SCAN_CYC);
        else n_pass++;
        n_checks++;
        if (res0 !== box(1'b1, 3, 3, 7, 7)) $display("FAIL single_box: got %h want %h", res0, box(1'b1, 3, 3, 7, 7));
        else n_pass++;
        n_checks++;
        if (seen_at[71] !== scan_id) $display("FAIL single_addr71: got scan %0d want %0d", seen_at[71], scan_id);
        else n_pass++;
        n_checks++;
        if (res1 !== 45'd0) $display("FAIL single_tol_bg: got %h want 0", res1);
        else n_pass++;
    endtask

    task automatic test_corners();
        int cyc;
        fill_bg();
        img_g[0][0] = 8'h00;
        img_b[9][9] = 8'h00;
        run_scan(cyc);
        n_checks++;
        if (res0 !== box(1'b1, 0, 9, 0, 9)) $display("FAIL corners_box: got %h want %h", res0, box(1'b1, 0, 9, 0, 9));
        else n_pass++;
        n_checks++;
        if (res1 !== box(1'b1, 0, 9, 0, 9)) $display("FAIL corners_box_tol: got %h want %h", res1, box(1'b1, 0, 9, 0, 9));
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (seen_at[270 + k] !== scan_id || seen_at[27 + k] !== scan_id)
                $display("FAIL corners_addr_%0d: got scans %0d/%0d want %0d", k, seen_at[270 + k], seen_at[27 + k], scan_id);
            else n_pass++;
        end
    endtask

    task automatic test_tol();
        int cyc;
        fill_bg();
        img_g[1][1] = 8'hFD;
        img_b[6][5] = 8'hFC;
        run_scan(cyc);
        n_checks++;
        if (res1 !== box(1'b1, 5, 5, 6, 6)) $display("FAIL tol_box: got %h want %h", res1, box(1'b1, 5, 5, 6, 6));
        else n_pass++;
        n_checks++;
        if (res0 !== box(1'b1, 1, 5, 1, 6)) $display("FAIL tol0_box: got %h want %h", res0, box(1'b1, 1, 5, 1, 6));
        else n_pass++;
    endtask

    task automatic test_restart();
        int n;
        logic [44:0] old_box;
        old_box = box(1'b1, 1, 5, 1, 6);
        fill_bg();
        img_r[1][2] = 8'h00;
        img_g[4][5] = 8'h00;
        scan_id++;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n_checks++;
        if (done0 !== 1'b0 || res0 !== old_box) $display("FAIL restart_drop: got done %b box %h want done 0 box %h", done0, res0, old_box);
        else n_pass++;
        n = 0;
        while (!done0 && n < 4000) begin
            @(posedge clk); #1;
            n++;
            if (n == 300) begin
                n_checks++;
                if (res0 !== old_box) $display("FAIL restart_hold: got %h want %h", res0, old_box);
                else n_pass++;
            end
        end
        n_checks++;
        if (n + 1 !== SCAN_CYC) $display("FAIL restart_latency: got %0d want %0d", n + 1, SCAN_CYC);
        else n_pass++;
        n_checks++;
        if (res0 !== box(1'b1, 2, 5, 1, 4)) $display("FAIL restart_box: got %h want %h", res0, box(1'b1, 2, 5, 1, 4));
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int cyc;
        fill_bg();
        img_b[8][4] = 8'h10;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (249) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({done0, res0, done1, res1} !== 92'd0) $display("FAIL midreset_outputs: got %h want 0", {done0, res0, done1, res1});
        else n_pass++;
        n_checks++;
        if (addr0 !== 32'd0) $display("FAIL midreset_addr: got %0d want 0", addr0);
        else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++;
        if (done0 !== 1'b0 || addr0 !== 32'd0) $display("FAIL midreset_idle: got done %b addr %0d want 0/0", done0, addr0);
        else n_pass++;
        run_scan(cyc);
        n_checks++;
        if (cyc !== SCAN_CYC) $display("FAIL midreset_latency: got %0d want %0d", cyc, SCAN_CYC);
        else n_pass++;
        n_checks++;
        if (res0 !== box(1'b1, 4, 4, 8, 8)) $display("FAIL midreset_box: got %h want %h", res0, box(1'b1, 4, 4, 8, 8));
        else n_pass++;
    endtask

    task automatic test_random();
        int cyc, sel;
        logic [44:0] exp0, exp1;
        for (int it = 0; it < 6; it++) begin
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) begin
                    sel = int'($urandom_range(0, 39));
                    if (sel < 36 - 6 * (it % 2)) begin
                        img_r[y][x] = 8'hFF; img_g[y][x] = 8'hFF; img_b[y][x] = 8'hFF;
                    end else if (sel < 38) begin
                        img_r[y][x] = 8'($urandom_range(250, 255));
                        img_g[y][x] = 8'($urandom_range(250, 255));
                        img_b[y][x] = 8'($urandom_range(250, 255));
                    end else begin
                        img_r[y][x] = 8'($urandom); img_g[y][x] = 8'($urandom); img_b[y][x] = 8'($urandom);
                    end
                end
            exp0 = ref_box(0);
            exp1 = ref_box(2);
            run_scan(cyc);
            n_checks++;
            if (cyc !== SCAN_CYC) $display("FAIL rand%0d_latency: got %0d want %0d", it, cyc, SCAN_CYC);
            else n_pass++;
            n_checks++;
            if (res0 !== exp0) $display("FAIL rand%0d_box: got %h want %h", it, res0, exp0);
            else n_pass++;
            n_checks++;
            if (res1 !== exp1) $display("FAIL rand%0d_box_tol: got %h want %h", it, res1, exp1);
            else n_pass++;
        end
    endtask

    initial begin
        fill_bg();
        test_reset();
        test_all_bg();
        test_single();
        test_corners();
        test_tol();
        test_restart();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
